// File: rtl/block_asm_pkg.sv
// Shared types and helpers for block_assembler: FSM state, default widths,
// and the pad-bit placement used when BLOCK_ASM_PAD_EN is defined.
package block_asm_pkg;

    typedef enum logic {FILL, HOLD} blk_state_t;

    localparam int DEF_IN_W    = 8;
    localparam int DEF_BLOCK_W = 512;

    // Bit index of the single pad 1 for a left-justified partial block of
    // `beats` beats: directly below the last beat. Only meaningful for beats < block_w/in_w.
    function automatic int pad_bit_pos(input int beats, input int in_w, input int block_w);
        return (block_w / in_w - beats) * in_w - 1;
    endfunction

endpackage

// File: rtl/block_assembler.sv
// Packs IN_W-bit beats into one BLOCK_W-bit block, holding it until the consumer takes it.
// Optional BLOCK_ASM_PAD_EN: partial blocks are left-justified with a single pad 1 below the last beat.
module block_assembler
    import block_asm_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int BLOCK_W = DEF_BLOCK_W,
    localparam int BEATS  = BLOCK_W / IN_W,
    localparam int CNT_W  = $clog2(BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_last,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic [CNT_W-1:0]   blk_beats
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and data is held while valid waits.
    blk_state_t         state;
    logic [BLOCK_W-1:0] shreg;
    logic [CNT_W-1:0]   count;

    logic               drain;
    logic               accept;
    logic               done;
    logic [BLOCK_W-1:0] base_shreg;
    logic [CNT_W-1:0]   base_count;
    logic [BLOCK_W-1:0] next_shreg;
    logic [CNT_W-1:0]   next_count;
    logic [BLOCK_W-1:0] fmt_data;

    assign drain    = blk_valid & blk_ready;
    assign in_ready = (state == FILL) | drain;
    assign accept   = in_valid & in_ready;

    // A beat arriving in the same cycle the held block drains starts a fresh block.
    assign base_shreg = drain ? '0 : shreg;
    assign base_count = drain ? '0 : count;
    assign next_shreg = (base_shreg << IN_W) | BLOCK_W'(in_data);
    assign next_count = base_count + CNT_W'(1);
    assign done       = accept & ((next_count == CNT_W'(BEATS)) | in_last);

    always_comb begin
        fmt_data = next_shreg;
`ifdef BLOCK_ASM_PAD_EN
        if (next_count != CNT_W'(BEATS))
            fmt_data = (next_shreg << ((BEATS - int'(next_count)) * IN_W))
                     | (BLOCK_W'(1) << pad_bit_pos(int'(next_count), IN_W, BLOCK_W));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            shreg     <= '0;
            count     <= '0;
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_beats <= '0;
        end else if (accept) begin
            shreg <= next_shreg;
            count <= next_count;
            if (done) begin
                state     <= HOLD;
                blk_valid <= 1'b1;
                blk_beats <= next_count;
                blk_data  <= fmt_data;
            end else if (state == HOLD) begin
                state     <= FILL;
                blk_valid <= 1'b0;
            end
        end else if (drain) begin
            state     <= FILL;
            shreg     <= '0;
            count     <= '0;
            blk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_block_assembler.sv
// Directed bench for block_assembler: a queue-based block model checked every cycle,
// plus hand-computed literal expectations (8/32 instance and a default 8/512 instance).
module tb_block_assembler;

    localparam int BEATS = 4;

    logic        tb_clk    = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_last   = 1'b0;
    logic        blk_ready = 1'b1;
    logic [7:0]  in_data   = '0;
    logic        in_ready;
    logic        blk_valid;
    logic [31:0] blk_data;
    logic [2:0]  blk_beats;

    logic         b_in_valid  = 1'b0;
    logic         b_in_last   = 1'b0;
    logic         b_blk_ready = 1'b1;
    logic [7:0]   b_in_data   = '0;
    logic         b_in_ready;
    logic         b_blk_valid;
    logic [511:0] b_blk_data;
    logic [6:0]   b_blk_beats;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 0;

    always #5 tb_clk = ~tb_clk;

    block_assembler #(.IN_W(8), .BLOCK_W(32)) dut (
        .clk(tb_clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_beats(blk_beats)
    );

    block_assembler dut_big (
        .clk(tb_clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .blk_valid(b_blk_valid), .blk_ready(b_blk_ready), .blk_data(b_blk_data), .blk_beats(b_blk_beats)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: beats collected in a queue; a block is formed from the queue contents.
    logic [7:0]  m_q[$];
    bit          m_hold = 0;
    logic [31:0] m_data = '0;
    int          m_n    = 0;

    function automatic logic [31:0] pack_blk(input logic [7:0] q[$]);
        logic [31:0] r;
        int n;
        r = '0;
        n = q.size();
`ifdef BLOCK_ASM_PAD_EN
        for (int i = 0; i < n; i++) r |= 32'(q[i]) << (8 * (BEATS - 1 - i));
        if (n < BEATS) r |= 32'(1) << (8 * (BEATS - n) - 1);
`else
        for (int i = 0; i < n; i++) r |= 32'(q[i]) << (8 * (n - 1 - i));
`endif
        return r;
    endfunction

    initial forever begin
        bit rdy;
        @(posedge tb_clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_hold = 0;
            m_data = '0;
            m_n    = 0;
        end else begin
            rdy = !m_hold || blk_ready;
            if (m_hold && blk_ready) m_hold = 0;
            if (in_valid && rdy) begin
                m_q.push_back(in_data);
                if (m_q.size() == BEATS || in_last) begin
                    m_hold = 1;
                    m_data = pack_blk(m_q);
                    m_n    = m_q.size();
                    m_q.delete();
                end
            end
        end
    end

    initial forever begin
        @(negedge tb_clk);
        if (!done) begin
            check("in_ready",  512'(in_ready),  512'(!m_hold || blk_ready));
            check("blk_valid", 512'(blk_valid), 512'(m_hold));
            check("blk_beats", 512'(blk_beats), 512'(m_n));
            check("blk_data",  512'(blk_data),  512'(m_data));
        end
    end

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int   t = 0;
        logic r;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge tb_clk);
            r = in_ready;
            @(posedge tb_clk);
            t++;
        end while (!r && t < 50);
        if (!r) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat %0h not accepted within %0d cycles", d, t);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    localparam logic [31:0] P2 =
`ifdef BLOCK_ASM_PAD_EN
        32'h11228000;
`else
        32'h00001122;
`endif
    localparam logic [31:0] P1 =
`ifdef BLOCK_ASM_PAD_EN
        32'h5A800000;
`else
        32'h0000005A;
`endif
    localparam logic [31:0] P3 =
`ifdef BLOCK_ASM_PAD_EN
        32'hABCDEF80;
`else
        32'h00ABCDEF;
`endif

    initial begin
        @(negedge tb_clk);
        check("rst_blk_valid", 512'(blk_valid), 512'(0));
        check("rst_in_ready",  512'(in_ready),  512'(1));
        repeat (2) @(posedge tb_clk);
        #1 rst = 1'b0;

        // Full block, consumer ready
        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'hD4, 0);
        @(negedge tb_clk);
        check("full_valid", 512'(blk_valid), 512'(1));
        check("full_data",  512'(blk_data),  512'(32'hA1B2C3D4));
        check("full_beats", 512'(blk_beats), 512'(4));
        step();

        // Backpressure
        blk_ready = 1'b0;
        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'hD4, 0);
        repeat (5) begin
            @(negedge tb_clk);
            check("bp_in_ready", 512'(in_ready), 512'(0));
            check("bp_data",     512'(blk_data), 512'(32'hA1B2C3D4));
        end
        step();
        blk_ready = 1'b1;
        @(negedge tb_clk);
        check("bp_release_ready", 512'(in_ready), 512'(1));
        step();
        @(negedge tb_clk);
        check("bp_drained", 512'(blk_valid), 512'(0));
        step();

        // Partial blocks and redundant in_last on the final beat
        send(8'h11, 0); send(8'h22, 1);
        @(negedge tb_clk);
        check("p2_beats", 512'(blk_beats), 512'(2));
        check("p2_data",  512'(blk_data),  512'(P2));
        step();
        send(8'h5A, 1);
        @(negedge tb_clk);
        check("p1_beats", 512'(blk_beats), 512'(1));
        check("p1_data",  512'(blk_data),  512'(P1));
        step();
        send(8'hAB, 0); send(8'hCD, 0); send(8'hEF, 1);
        @(negedge tb_clk);
        check("p3_beats", 512'(blk_beats), 512'(3));
        check("p3_data",  512'(blk_data),  512'(P3));
        step();
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        @(negedge tb_clk);
        check("last4_data",  512'(blk_data),  512'(32'h01020304));
        check("last4_beats", 512'(blk_beats), 512'(4));
        step();

        // Back-to-back drain + accept
        blk_ready = 1'b0;
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
        step();
        blk_ready = 1'b1;
        send(8'h55, 0);
        @(negedge tb_clk);
        check("b2b_released", 512'(blk_valid), 512'(0));
        step();
        send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        @(negedge tb_clk);
        check("b2b_data",  512'(blk_data),  512'(32'h55667788));
        check("b2b_beats", 512'(blk_beats), 512'(4));
        step();

        // Reset mid-fill
        send(8'h99, 0); send(8'h9A, 0);
        rst = 1'b1;
        @(negedge tb_clk);
        check("mid_rst_valid", 512'(blk_valid), 512'(0));
        check("mid_rst_data",  512'(blk_data),  512'(0));
        check("mid_rst_beats", 512'(blk_beats), 512'(0));
        step();
        rst = 1'b0;
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        @(negedge tb_clk);
        check("post_rst_data",  512'(blk_data),  512'(32'hAABBCCDD));
        check("post_rst_beats", 512'(blk_beats), 512'(4));
        step();

        // Default parameters, 64 beats 00..3F
        for (int i = 0; i < 64; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'(i);
            @(negedge tb_clk);
            check("big_in_ready", 512'(b_in_ready), 512'(1));
            step();
        end
        b_in_valid = 1'b0;
        @(negedge tb_clk);
        check("big_valid",   512'(b_blk_valid),         512'(1));
        check("big_beats",   512'(b_blk_beats),         512'(64));
        check("big_msb",     512'(b_blk_data[511:504]), 512'(8'h00));
        check("big_lsb",     512'(b_blk_data[7:0]),     512'(8'h3F));
        check("big_lsb1",    512'(b_blk_data[15:8]),    512'(8'h3E));
        check("big_mid",     512'(b_blk_data[263:256]), 512'(8'h1F));

        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
